// File: rtl/row_clear_engine.sv
// Row-clear engine: scans a settled playfield bottom-up, drops full rows and
// compacts the survivors downward one row per clock, then reports the result.
module row_clear_engine #(
  parameter int ROWS    = 22,
  parameter int COLS    = 10,
  parameter int TOTAL_W = 16
) (
  input  logic               Clk,
  input  logic               Reset_h,
  input  logic               start,
  input  logic [COLS-1:0]    board_in [ROWS],
  output logic [COLS-1:0]    board_out [ROWS],
  output logic [4:0]         lines_cleared,
  output logic [TOTAL_W-1:0] total_lines,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t            state;
  logic [COLS-1:0]   src_q [ROWS];
  logic [COLS-1:0]   work  [ROWS];
  logic [IDX_W-1:0]  src_ptr;
  logic [IDX_W-1:0]  dst_ptr;
  logic [4:0]        cnt;
  logic              row_full;

  function automatic logic [TOTAL_W-1:0] sat_add(input logic [TOTAL_W-1:0] a,
                                                 input logic [4:0]         b);
    logic [TOTAL_W:0] s;
    s = {1'b0, a} + (TOTAL_W + 1)'(b);
    if (s[TOTAL_W]) return '1;
    return s[TOTAL_W-1:0];
  endfunction

  assign row_full = &src_q[src_ptr];

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state <= IDLE;
      for (int r = 0; r < ROWS; r++) begin
        src_q[r]     <= '0;
        work[r]      <= '0;
        board_out[r] <= '0;
      end
      src_ptr       <= '0;
      dst_ptr       <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The cycle that shows done is still not an accept slot.
        IDLE: begin
          if (start && !done) begin
            for (int r = 0; r < ROWS; r++) src_q[r] <= board_in[r];
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            cnt <= cnt + 5'd1;
          end else begin
            work[dst_ptr] <= src_q[src_ptr];
            dst_ptr       <= dst_ptr + ONE;
          end
          if (src_ptr == LAST) begin
            state <= (row_full || cnt != 5'd0) ? FILL : DONE;
          end else begin
            src_ptr <= src_ptr + ONE;
          end
        end
        // Top rows vacated by cleared lines become empty.
        FILL: begin
          work[dst_ptr] <= '0;
          dst_ptr       <= dst_ptr + ONE;
          if (dst_ptr == LAST) state <= DONE;
        end
        DONE: begin
          for (int r = 0; r < ROWS; r++) board_out[r] <= work[r];
          lines_cleared <= cnt;
          total_lines   <= sat_add(total_lines, cnt);
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_clear_engine.sv
// Bench for row_clear_engine: table vectors, randomized boards against a
// queue-based reference, plus busy, reset and saturation sequences.
module tb_row_clear_engine;
  localparam int ROWS = 22;
  localparam int COLS = 10;

  typedef logic [ROWS-1:0][COLS-1:0] brd_t;
  typedef struct packed {
    brd_t       b;
    brd_t       eb;
    logic [4:0] n;
  } vec_t;

  logic              Clk;
  logic              Reset_h;
  logic              start;
  logic [COLS-1:0]   board_in [ROWS];
  logic [COLS-1:0]   board_out [ROWS];
  logic [4:0]        lines_cleared;
  logic [15:0]       total_lines;
  logic              busy;
  logic              done;
  logic [COLS-1:0]   s_board_out [ROWS];
  logic [4:0]        s_lines;
  logic [5:0]        s_total;
  logic              s_busy;
  logic              s_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_total = 0;
  int exp_sat   = 0;
  vec_t tbl [4];

  row_clear_engine dut (
    .Clk(Clk), .Reset_h(Reset_h), .start(start), .board_in(board_in),
    .board_out(board_out), .lines_cleared(lines_cleared),
    .total_lines(total_lines), .busy(busy), .done(done)
  );

  row_clear_engine #(.ROWS(ROWS), .COLS(COLS), .TOTAL_W(6)) u_sat (
    .Clk(Clk), .Reset_h(Reset_h), .start(start), .board_in(board_in),
    .board_out(s_board_out), .lines_cleared(s_lines),
    .total_lines(s_total), .busy(s_busy), .done(s_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_board(input string name, input brd_t eb);
    int bad = -1;
    for (int r = 0; r < ROWS; r++)
      if (board_out[r] !== eb[r] && bad < 0) bad = r;
    n_cmp++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: row %0d actual=%0h required=%0h", name, bad, board_out[bad], eb[bad]);
    end
  endtask

  task automatic set_board(input brd_t b);
    for (int r = 0; r < ROWS; r++) board_in[r] = b[r];
  endtask

  // Reference: keep non-full rows in order, pad the top with empty rows.
  task automatic model(input brd_t b, output brd_t o, output int n);
    logic [COLS-1:0] keep [$];
    keep = {};
    n = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (b[r] == {COLS{1'b1}}) n++;
      else keep.push_back(b[r]);
    end
    o = '0;
    foreach (keep[i]) o[i] = keep[i];
  endtask

  task automatic account(input int n);
    exp_total = (exp_total + n > 65535) ? 65535 : exp_total + n;
    exp_sat   = (exp_sat + n > 63) ? 63 : exp_sat + n;
  endtask

  task automatic run_op(input brd_t b, input brd_t eb, input int en, input string tag);
    int k = 0;
    bit seen = 0;
    set_board(b);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, " busy_after_accept"}, busy, 1);
    while (!seen && k < 80) begin
      tick();
      k++;
      if (done) seen = 1;
    end
    account(en);
    chk({tag, " latency"}, k, ROWS + en + 1);
    chk({tag, " lines"}, lines_cleared, en);
    chk_board({tag, " board"}, eb);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " total"}, total_lines, exp_total);
    chk({tag, " sat_total"}, s_total, exp_sat);
    tick();
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    brd_t b, eb, tetris, tet_exp;
    int n, dones, first_lat;

    Reset_h = 1'b1;
    start   = 1'b0;
    set_board('0);
    tick();
    tick();
    Reset_h = 1'b0;
    chk_board("reset board", '0);
    chk("reset lines", lines_cleared, 0);
    chk("reset total", total_lines, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);

    for (int i = 0; i < 4; i++) tbl[i] = '0;
    for (int r = 0; r < 4; r++) begin
      tbl[0].b[r] = 10'h1FF;
      tbl[0].eb[r] = 10'h1FF;
      tbl[1].b[r] = 10'h3FF;
    end
    tbl[0].n = 5'd0;
    tbl[1].b[4] = 10'h001;  tbl[1].b[5] = 10'h200;
    tbl[1].eb[0] = 10'h001; tbl[1].eb[1] = 10'h200;
    tbl[1].n = 5'd4;
    tbl[2].b[0] = 10'h3FF;  tbl[2].b[1] = 10'h0F0;
    tbl[2].b[2] = 10'h3FF;  tbl[2].b[3] = 10'h00F;
    tbl[2].eb[0] = 10'h0F0; tbl[2].eb[1] = 10'h00F;
    tbl[2].n = 5'd2;
    for (int r = 0; r < ROWS; r++) tbl[3].b[r] = 10'h3FF;
    tbl[3].n = 5'd22;

    for (int i = 0; i < 4; i++)
      run_op(tbl[i].b, tbl[i].eb, int'(tbl[i].n), $sformatf("vec%0d", i));

    // Second start mid-scan, board change while busy, start in the done cycle.
    tetris = tbl[1].b;
    tet_exp = tbl[1].eb;
    set_board(tetris);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    start = 1'b1;
    set_board(tbl[3].b);
    tick();
    start = 1'b0;
    dones = 0;
    first_lat = -1;
    for (int k = 7; k <= 100; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        dones++;
        if (first_lat < 0) begin
          first_lat = k;
          start = 1'b1;
        end
      end
    end
    start = 1'b0;
    account(4);
    chk("busy_seq dones", dones, 1);
    chk("busy_seq latency", first_lat, ROWS + 4 + 1);
    chk_board("busy_seq board", tet_exp);
    chk("busy_seq total", total_lines, exp_total);
    chk("busy_seq idle", busy, 0);

    for (int it = 0; it < 25; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 3))
          0, 1:    b[r] = 10'h3FF;
          2:       b[r] = '0;
          default: b[r] = COLS'($urandom);
        endcase
      end
      model(b, eb, n);
      run_op(b, eb, n, $sformatf("rnd%0d", it));
    end

    // Reset while filling.
    set_board(tetris);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < ROWS + 2; i++) tick();
    Reset_h = 1'b1;
    tick();
    Reset_h = 1'b0;
    exp_total = 0;
    exp_sat = 0;
    chk_board("rst_fill board", '0);
    chk("rst_fill busy", busy, 0);
    chk("rst_fill done", done, 0);
    chk("rst_fill total", total_lines, 0);
    chk("rst_fill sat_total", s_total, 0);
    run_op(tetris, tet_exp, 4, "after_rst");

    for (int i = 0; i < 3; i++)
      run_op(tbl[3].b, '0, 22, $sformatf("full%0d", i));
    chk("sat final", s_total, 6'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
